ex_mul_div: RTL and testbench
=============================

# ex_mul_div

Iterative RV64M multiply/divide unit in the EX stage. It accepts one M-extension operation from the ID_EX register and computes it over 64 iterations. While it works, it drives the mul/div stall request into pipeline control, which stalls PC/Pre_IF/IF_ID and flushes EX_MEM. It releases the stall when the result is ready, and abandons work on a trap/jump flush. Divide-by-zero and signed overflow complete in the same cycle with no stall.

## Interface
- No parameters (XLEN fixed at 64; op encodings come from `sysconfig.v`).
- `clk  in  1`: pipeline clock.
- `rst_n  in  1`: asynchronous reset, active-low.
- `valid_i  in  1`: EX holds a valid M-extension instruction.
- `op_i  in  4`: operation code (see Operation).
- `src1_i  in  64`: rs1 operand, forwarded.
- `src2_i  in  64`: rs2 operand, forwarded.
- `flush_i  in  1`: EX instruction is being flushed; abandon work.
- `hold_i  in  1`: a later stage is stalling EX; keep the result.
- `stall_req_o  out  1`: connects to the `alu_mul_div_valid_ex_i` input of pipeline control.
- `result_valid_o  out  1`: `result_o` is valid this cycle.
- `result_o  out  64`: final result.

## Operation
- Op codes:
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU
  - 8 MULW, 12 DIVW, 13 DIVUW, 14 REMW, 15 REMUW
  - 9–11 reserved: treated as not valid (no stall, `result_valid_o`=0).
- W ops:
  - Operands are the low 32 bits, sign-extended (MULW/DIVW/REMW) or zero-extended (DIVUW/REMUW) to 64 bits.
  - Result is the low 32 bits of the 64-bit result, sign-extended.
- Multiply:
  - Take operand magnitudes per signedness: MULHSU treats rs1 as signed and rs2 as unsigned.
  - Run an unsigned 64×64 shift-add, one bit per iteration, into a 128-bit product.
  - Negate the 128-bit product if the operand signs differ.
  - MUL/MULW return the low 64 bits; MULH* return the high 64 bits.
- Divide:
  - Restoring division on magnitudes, one quotient bit per iteration, using a 65-bit partial remainder.
  - Quotient is negated if the signs differ (signed ops only).
  - Remainder takes the dividend's sign.
- Fast paths, combinational in IDLE; `result_valid_o`=1 and `stall_req_o`=0 in the same cycle, FSM stays IDLE:
  - Divisor zero (64-bit, or low 32 bits for W ops): quotient all-ones; remainder = dividend (sign-extended for W ops).
  - DIV/REM with rs1=0x8000_0000_0000_0000 and rs2=−1: quotient = rs1, remainder = 0.
- FSM states IDLE, BUSY, DONE:
  - IDLE → BUSY when `valid_i & ~flush_i &` legal op `& ~`fast path. This start is combinational: `stall_req_o`=1 in the accept cycle. Operands, op and sign flags are latched; counter cleared.
  - BUSY: `stall_req_o`=1, one iteration per cycle, 7-bit counter. When the counter reaches 63 → DONE.
  - DONE: `stall_req_o`=0, `result_valid_o`=1, `result_o` from the latched/sign-fixed registers. → IDLE unless `hold_i`; if held, stay in DONE with the result stable. No restart on the still-present `valid_i`.
  - `flush_i` in BUSY or DONE → IDLE next cycle; the result is discarded.
- Reset, asynchronous, any state:
  - FSM → IDLE; counter, operand and result registers → 0.
  - `stall_req_o`=0, `result_valid_o`=0, `result_o`=0 (the fast-path combinational term is blocked while `rst_n`=0).

## Timing
- Accepted at cycle T → `stall_req_o` high T..T+64 (65 cycles) → `result_valid_o` at T+65. The pipeline consumes the result at the T+65 edge.
- Fast path: 0-cycle latency, combinational from the inputs.
- `flush_i` at cycle F (BUSY) → `stall_req_o` low at F+1. A new op may be accepted at F+1.
- Back-to-back M ops: the second op is accepted in the IDLE cycle after DONE (one idle cycle minimum).
- `hold_i` is only sampled in DONE. In IDLE/BUSY it has no effect; pipeline control already prioritises later stalls.

## Structure
- `sysconfig.v` gets the `MDU_OP_*` defines (4-bit codes above) and `XLEN`=64.
- One sub-module: `mdu_iter_core`.
  - Contains the shared 128-bit shift register (product / {remainder, quotient}) and the 65-bit adder/subtractor.
  - Takes a mode bit and steps once per enable.
  - Sign correction and W-op extension stay in `ex_mul_div`.

## Test plan
- MUL, 3 × 0xFFFF_FFFF_FFFF_FFFB: `stall_req_o` high T..T+64; at T+65 `result_o`=0xFFFF_FFFF_FFFF_FFF1, `result_valid_o`=1.
- MULHU, all-ones × all-ones → 0xFFFF_FFFF_FFFF_FFFE. MULHSU, −1 × 2 → 0xFFFF_FFFF_FFFF_FFFF. Both at T+65.
- DIVU 0x1234/0 → 0xFFFF_FFFF_FFFF_FFFF and REM 0x1234/0 → 0x1234, same cycle, `stall_req_o` never high. DIV min/−1 → 0x8000_0000_0000_0000; REM min/−1 → 0; both same cycle.
- DIV started at T, `flush_i` at T+20 → `stall_req_o`=0 at T+21, no `result_valid_o`. Then DIVW −7/2 → 0xFFFF_FFFF_FFFF_FFFD and REMW −7/2 → 0xFFFF_FFFF_FFFF_FFFF.
- `hold_i`=1 for 3 cycles in DONE: result held stable 4 cycles, no restart, `stall_req_o` stays 0. Returns to IDLE after `hold_i` drops.
- `rst_n` low at T+30 of a MULH → all outputs 0 asynchronously. After release, `valid_i` with DIVUW 100/7 → 14 at T'+65.

Source files
------------

// File: rtl/ex_mul_div_pkg.sv
// Shared definitions for the iterative RV64M multiply/divide unit:
// op encodings, datapath width, FSM states and W-op extension helper.
package ex_mul_div_pkg;

    localparam int XLEN = 64;

    localparam logic [3:0] MDU_OP_MUL    = 4'd0;
    localparam logic [3:0] MDU_OP_MULH   = 4'd1;
    localparam logic [3:0] MDU_OP_MULHSU = 4'd2;
    localparam logic [3:0] MDU_OP_MULHU  = 4'd3;
    localparam logic [3:0] MDU_OP_DIV    = 4'd4;
    localparam logic [3:0] MDU_OP_DIVU   = 4'd5;
    localparam logic [3:0] MDU_OP_REM    = 4'd6;
    localparam logic [3:0] MDU_OP_REMU   = 4'd7;
    localparam logic [3:0] MDU_OP_MULW   = 4'd8;
    localparam logic [3:0] MDU_OP_DIVW   = 4'd12;
    localparam logic [3:0] MDU_OP_DIVUW  = 4'd13;
    localparam logic [3:0] MDU_OP_REMW   = 4'd14;
    localparam logic [3:0] MDU_OP_REMUW  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    function automatic logic [XLEN-1:0] sext_w(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/ex_mul_div_iter_core.sv
// Shared iteration datapath: 128-bit accumulator (product, or {remainder, quotient})
// plus a 65-bit adder/subtractor; one shift-add or restoring-divide step per enable.
module mdu_iter_core
    import ex_mul_div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic                  div_mode_i,
    input  logic [XLEN-1:0]       opnd_i,
    input  logic [XLEN-1:0]       init_i,
    output logic [2*XLEN-1:0]     acc_o
);

    logic [2*XLEN-1:0] acc_q, acc_d, acc_step_s;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   hi_s, lo_s;
    logic [XLEN:0]     rem_sh_s, add_a_s, add_b_s;
    logic              cin_s;
    logic [XLEN+1:0]   sum_s;

    // One iteration step and load/hold selection
    always_comb begin
        hi_s     = acc_q[2*XLEN-1:XLEN];
        lo_s     = acc_q[XLEN-1:0];
        rem_sh_s = {hi_s, lo_s[XLEN-1]};
        if (div_mode_i) begin
            add_a_s = rem_sh_s;
            add_b_s = ~{1'b0, opnd_q};
            cin_s   = 1'b1;
        end else begin
            add_a_s = {1'b0, hi_s};
            add_b_s = {1'b0, opnd_q};
            cin_s   = 1'b0;
        end
        sum_s = {1'b0, add_a_s} + {1'b0, add_b_s} + {{(XLEN+1){1'b0}}, cin_s};

        // For division the carry out is the "no borrow" flag: remainder >= divisor
        if (div_mode_i) begin
            if (sum_s[XLEN+1]) begin
                acc_step_s = {sum_s[XLEN-1:0], lo_s[XLEN-2:0], 1'b1};
            end else begin
                acc_step_s = {rem_sh_s[XLEN-1:0], lo_s[XLEN-2:0], 1'b0};
            end
        end else begin
            if (lo_s[0]) begin
                acc_step_s = {sum_s[XLEN:0], lo_s[XLEN-1:1]};
            end else begin
                acc_step_s = {1'b0, hi_s, lo_s[XLEN-1:1]};
            end
        end

        acc_d  = acc_q;
        opnd_d = opnd_q;
        if (load_i) begin
            acc_d  = {{XLEN{1'b0}}, init_i};
            opnd_d = opnd_i;
        end else if (step_i) begin
            acc_d  = acc_step_s;
        end else begin
            acc_d  = acc_q;
        end
    end

    // Accumulator and operand registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= {(2*XLEN){1'b0}};
            opnd_q <= {XLEN{1'b0}};
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/ex_mul_div.sv
// EX-stage iterative RV64M multiply/divide unit: 64-iteration shift-add / restoring
// divide with a pipeline stall request, zero-latency divide fast paths and flush/hold.
module ex_mul_div
    import ex_mul_div_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            flush_i,
    input  logic            hold_i,
    output logic            stall_req_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o
);

    mdu_state_e state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic       is_w_q, is_w_d;
    logic       div_q, div_d;
    logic       rem_q, rem_d;
    logic       hi_q, hi_d;
    logic       neg_res_q, neg_res_d;
    logic       neg_rem_q, neg_rem_d;

    logic            is_w_s, legal_s, a_signed_s, b_signed_s, neg_a_s, neg_b_s;
    logic [XLEN-1:0] a_ext_s, b_ext_s, mag_a_s, mag_b_s;
    logic            div_zero_s, ovf_s, fast_s, req_s, start_s, fast_hit_s;
    logic [XLEN-1:0] fast_raw_s, fast_res_s;
    logic            load_s, step_s;
    logic [XLEN-1:0] core_opnd_s, core_init_s;
    logic [2*XLEN-1:0] acc_s, prod_s;
    logic [XLEN-1:0] quo_s, remv_s, done_raw_s, done_res_s;
    logic            done_out_s;

    // Operand decode, W-op extension, magnitudes and fast-path detection
    always_comb begin
        is_w_s  = op_i[3];
        legal_s = ~(op_i[3] & ~op_i[2] & (op_i[1:0] != 2'b00));

        case (op_i)
            MDU_OP_MUL, MDU_OP_MULH, MDU_OP_MULW,
            MDU_OP_DIV, MDU_OP_REM, MDU_OP_DIVW, MDU_OP_REMW: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            MDU_OP_MULHSU: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b0;
            end
            MDU_OP_MULHU, MDU_OP_DIVU, MDU_OP_REMU,
            MDU_OP_DIVUW, MDU_OP_REMUW: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase

        // Even W op codes sign-extend their 32-bit operands, odd ones zero-extend
        if (is_w_s) begin
            if (!op_i[0]) begin
                a_ext_s = sext_w(src1_i[31:0]);
                b_ext_s = sext_w(src2_i[31:0]);
            end else begin
                a_ext_s = {32'd0, src1_i[31:0]};
                b_ext_s = {32'd0, src2_i[31:0]};
            end
        end else begin
            a_ext_s = src1_i;
            b_ext_s = src2_i;
        end

        neg_a_s = a_signed_s & a_ext_s[XLEN-1];
        neg_b_s = b_signed_s & b_ext_s[XLEN-1];
        mag_a_s = neg_a_s ? ({XLEN{1'b0}} - a_ext_s) : a_ext_s;
        mag_b_s = neg_b_s ? ({XLEN{1'b0}} - b_ext_s) : b_ext_s;

        div_zero_s = op_i[2] & (b_ext_s == {XLEN{1'b0}});
        ovf_s      = ~is_w_s & op_i[2] & ~op_i[0]
                   & (a_ext_s == {1'b1, {(XLEN-1){1'b0}}})
                   & (b_ext_s == {XLEN{1'b1}});
        fast_s     = legal_s & (div_zero_s | ovf_s);

        if (div_zero_s) begin
            fast_raw_s = op_i[1] ? a_ext_s : {XLEN{1'b1}};
        end else begin
            fast_raw_s = op_i[1] ? {XLEN{1'b0}} : a_ext_s;
        end
        fast_res_s = is_w_s ? sext_w(fast_raw_s[31:0]) : fast_raw_s;

        req_s      = rst_n & (state_q == ST_IDLE) & valid_i & ~flush_i & legal_s;
        start_s    = req_s & ~fast_s;
        fast_hit_s = req_s & fast_s;

        core_opnd_s = op_i[2] ? mag_b_s : mag_a_s;
        core_init_s = op_i[2] ? mag_a_s : mag_b_s;
    end

    // FSM next state, iteration counter and operation flag capture
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_w_d    = is_w_q;
        div_d     = div_q;
        rem_d     = rem_q;
        hi_d      = hi_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        load_s    = 1'b0;
        step_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d   = ST_BUSY;
                    cnt_d     = 7'd0;
                    load_s    = 1'b1;
                    is_w_d    = is_w_s;
                    div_d     = op_i[2];
                    rem_d     = op_i[1];
                    hi_d      = ~op_i[3] & ~op_i[2] & (op_i[1:0] != 2'b00);
                    neg_res_d = neg_a_s ^ neg_b_s;
                    neg_rem_d = neg_a_s;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    step_s = 1'b1;
                    cnt_d  = cnt_q + 7'd1;
                    if (cnt_q == 7'd63) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_DONE: begin
                if (flush_i || !hold_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and latched operation flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 7'd0;
            is_w_q    <= 1'b0;
            div_q     <= 1'b0;
            rem_q     <= 1'b0;
            hi_q      <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_w_q    <= is_w_d;
            div_q     <= div_d;
            rem_q     <= rem_d;
            hi_q      <= hi_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    mdu_iter_core u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load_s),
        .step_i     (step_s),
        .div_mode_i (div_q),
        .opnd_i     (core_opnd_s),
        .init_i     (core_init_s),
        .acc_o      (acc_s)
    );

    // Sign correction, result selection and output drive
    always_comb begin
        prod_s     = neg_res_q ? ({(2*XLEN){1'b0}} - acc_s) : acc_s;
        quo_s      = neg_res_q ? ({XLEN{1'b0}} - acc_s[XLEN-1:0]) : acc_s[XLEN-1:0];
        remv_s     = neg_rem_q ? ({XLEN{1'b0}} - acc_s[2*XLEN-1:XLEN])
                               : acc_s[2*XLEN-1:XLEN];
        if (div_q) begin
            done_raw_s = rem_q ? remv_s : quo_s;
        end else begin
            done_raw_s = hi_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
        end
        done_res_s = is_w_q ? sext_w(done_raw_s[31:0]) : done_raw_s;
        done_out_s = (state_q == ST_DONE) & ~flush_i;

        stall_req_o    = start_s | (state_q == ST_BUSY);
        result_valid_o = fast_hit_s | done_out_s;
        if (fast_hit_s) begin
            result_o = fast_res_s;
        end else if (done_out_s) begin
            result_o = done_res_s;
        end else begin
            result_o = {XLEN{1'b0}};
        end
    end

endmodule

// File: tb/tb_ex_mul_div.sv
// Directed self-checking bench for ex_mul_div: iterative ops, fast paths,
// flush, hold in DONE and asynchronous reset.
module tb_ex_mul_div;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic [3:0]  op_i;
    logic [63:0] src1_i;
    logic [63:0] src2_i;
    logic        flush_i;
    logic        hold_i;
    logic        stall_req_o;
    logic        result_valid_o;
    logic [63:0] result_o;

    int total;
    int bad;

    ex_mul_div dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_i        (valid_i),
        .op_i           (op_i),
        .src1_i         (src1_i),
        .src2_i         (src2_i),
        .flush_i        (flush_i),
        .hold_i         (hold_i),
        .stall_req_o    (stall_req_o),
        .result_valid_o (result_valid_o),
        .result_o       (result_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full iterative op: accept at T, busy T+1..T+64, result at T+65, idle at T+66
    task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp);
        int hi;
        valid_i = 1'b1;
        op_i    = op;
        src1_i  = a;
        src2_i  = b;
        #1;
        chk({tag, "_accept_stall"}, {63'd0, stall_req_o}, 64'd1);
        hi = 0;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (stall_req_o === 1'b1 && result_valid_o === 1'b0) hi++;
        end
        chk({tag, "_busy_cycles"}, 64'(hi), 64'd64);
        tick();
        chk({tag, "_valid"}, {63'd0, result_valid_o}, 64'd1);
        chk({tag, "_result"}, result_o, exp);
        chk({tag, "_done_stall"}, {63'd0, stall_req_o}, 64'd0);
        tick();
        valid_i = 1'b0;
        #1;
        chk({tag, "_idle_valid"}, {63'd0, result_valid_o}, 64'd0);
        chk({tag, "_idle_stall"}, {63'd0, stall_req_o}, 64'd0);
    endtask

    // Same-cycle fast path check in IDLE
    task automatic fast_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] exp);
        valid_i = 1'b1;
        op_i    = op;
        src1_i  = a;
        src2_i  = b;
        #1;
        chk({tag, "_valid"}, {63'd0, result_valid_o}, 64'd1);
        chk({tag, "_result"}, result_o, exp);
        chk({tag, "_stall"}, {63'd0, stall_req_o}, 64'd0);
        tick();
        chk({tag, "_still_idle"}, {63'd0, stall_req_o}, 64'd0);
        valid_i = 1'b0;
        #1;
    endtask

    initial begin
        int cnt;
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        valid_i = 1'b0;
        op_i    = 4'd0;
        src1_i  = 64'd0;
        src2_i  = 64'd0;
        flush_i = 1'b0;
        hold_i  = 1'b0;
        #3;
        chk("rst_stall", {63'd0, stall_req_o}, 64'd0);
        chk("rst_valid", {63'd0, result_valid_o}, 64'd0);
        chk("rst_result", result_o, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_op("mul", 4'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("mulhu", 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE);
        run_op("mulhsu", 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("div_neg", 4'd4, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2);
        run_op("rem_neg", 4'd6, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("remu", 4'd7, 64'd100, 64'd7, 64'd2);

        fast_op("divu_by0", 4'd5, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        fast_op("rem_by0", 4'd6, 64'h1234, 64'd0, 64'h1234);
        fast_op("div_ovf", 4'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h8000_0000_0000_0000);
        fast_op("rem_ovf", 4'd6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        fast_op("divw_by0", 4'd12, 64'd5, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);

        // Reserved op code: no stall, no result, no start
        valid_i = 1'b1;
        op_i    = 4'd9;
        src1_i  = 64'd6;
        src2_i  = 64'd3;
        #1;
        chk("rsvd_stall", {63'd0, stall_req_o}, 64'd0);
        chk("rsvd_valid", {63'd0, result_valid_o}, 64'd0);
        tick();
        chk("rsvd_no_start", {63'd0, stall_req_o}, 64'd0);
        valid_i = 1'b0;
        #1;

        // Flush during BUSY
        valid_i = 1'b1;
        op_i    = 4'd4;
        src1_i  = 64'd1000;
        src2_i  = 64'd3;
        #1;
        chk("flush_accept", {63'd0, stall_req_o}, 64'd1);
        for (int i = 1; i <= 20; i++) tick();
        flush_i = 1'b1;
        #1;
        chk("flush_cycle_stall", {63'd0, stall_req_o}, 64'd1);
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        #1;
        chk("flush_next_stall", {63'd0, stall_req_o}, 64'd0);
        chk("flush_next_valid", {63'd0, result_valid_o}, 64'd0);
        run_op("divw", 4'd12, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("remw", 4'd14, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);

        // Hold in DONE for three cycles
        valid_i = 1'b1;
        op_i    = 4'd8;
        src1_i  = 64'h0000_0000_7FFF_FFFF;
        src2_i  = 64'd2;
        #1;
        chk("hold_accept", {63'd0, stall_req_o}, 64'd1);
        for (int i = 1; i <= 65; i++) tick();
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            hold_i = (k < 3) ? 1'b1 : 1'b0;
            #1;
            if (result_valid_o === 1'b1 && stall_req_o === 1'b0 &&
                result_o === 64'hFFFF_FFFF_FFFF_FFFE) cnt++;
            if (k < 3) tick();
        end
        chk("hold_stable_cycles", 64'(cnt), 64'd4);
        tick();
        valid_i = 1'b0;
        #1;
        chk("hold_release_valid", {63'd0, result_valid_o}, 64'd0);
        chk("hold_release_stall", {63'd0, stall_req_o}, 64'd0);
        tick();

        // Asynchronous reset in the middle of a MULH
        valid_i = 1'b1;
        op_i    = 4'd1;
        src1_i  = 64'h8000_0000_0000_0000;
        src2_i  = 64'd2;
        #1;
        chk("mulh_accept", {63'd0, stall_req_o}, 64'd1);
        for (int i = 1; i <= 30; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_stall", {63'd0, stall_req_o}, 64'd0);
        chk("arst_valid", {63'd0, result_valid_o}, 64'd0);
        chk("arst_result", result_o, 64'd0);
        valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_stall", {63'd0, stall_req_o}, 64'd0);
        run_op("divuw", 4'd13, 64'hABCD_0000_0000_0064, 64'd7, 64'd14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
